// File: rtl/ram_rw_pkg.sv
// Shared types and helpers for the RAM write/read-back checker.
// Pattern words are computed 32 bits wide; callers truncate to their data width.
package ram_rw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int RD_LAT_MAX = 4;
  localparam int PAT_W      = 32;

  function automatic logic [PAT_W-1:0] pat(input logic [PAT_W-1:0] seed,
                                           input logic [PAT_W-1:0] addr);
    return seed + addr;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// RD_LAT-deep shift register carrying {valid, expected} alongside RAM reads,
// so the expected word lines up with the RAM's registered read data.
module ram_rd_pipe #(
  parameter int DW     = 8,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic [DW-1:0] in_exp,
  output logic          out_vld,
  output logic [DW-1:0] out_exp
);

  logic [RD_LAT-1:0]         vld_pipe;
  logic [RD_LAT-1:0][DW-1:0] exp_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      exp_pipe <= '0;
    end else begin
      vld_pipe[0] <= in_vld;
      exp_pipe[0] <= in_exp;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        exp_pipe[i] <= exp_pipe[i-1];
      end
    end
  end

  assign out_vld = vld_pipe[RD_LAT-1];
  assign out_exp = exp_pipe[RD_LAT-1];

endmodule

// File: rtl/ram_rw_ctrl.sv
// Write-pattern / read-back checker driving a single-port RAM.
// Optional build macro RAM_RW_CTRL_LOOP_EN: run passes back to back with seed+1 per pass.
module ram_rw_ctrl
  import ram_rw_pkg::*;
#(
  parameter int DW     = 8,
  parameter int AW     = 5,
  parameter int RD_LAT = 2,
  parameter int SEED   = 0,
  parameter int ECW    = 8
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  input  logic           start,
  output logic           ram_wren,
  output logic           ram_rden,
  output logic [AW-1:0]  ram_addr,
  output logic [DW-1:0]  ram_wdata,
  input  logic [DW-1:0]  ram_rdata,
  output logic           busy,
  output logic           done,
  output logic           err_flag,
  output logic [ECW-1:0] err_cnt
);

  localparam logic [AW-1:0] LAST_ADDR  = '1;
  localparam logic [2:0]    DRAIN_LAST = 3'(RD_LAT - 1);

  state_t           state;
  logic [AW-1:0]    cnt;
  logic [AW-1:0]    cnt_nx;
  logic [2:0]       dcnt;
  logic [PAT_W-1:0] seed_q;
  logic             accept;
  logic             pv;
  logic [DW-1:0]    pe;
  logic             mismatch;

  assign cnt_nx   = cnt + AW'(1);
  // start on the done cycle is dropped; the pass is only just returning to IDLE
  assign accept   = (state == IDLE) && start && !done;
  assign mismatch = pv && (ram_rdata != pe);

  ram_rd_pipe #(.DW(DW), .RD_LAT(RD_LAT)) u_rd_pipe (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .in_vld  (ram_rden),
    .in_exp  (DW'(pat(seed_q, PAT_W'(ram_addr)))),
    .out_vld (pv),
    .out_exp (pe)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dcnt      <= '0;
      seed_q    <= PAT_W'(SEED);
      ram_wren  <= 1'b0;
      ram_rden  <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_flag  <= 1'b0;
      err_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= WRITE;
            cnt       <= '0;
            seed_q    <= PAT_W'(SEED);
            ram_wren  <= 1'b1;
            ram_addr  <= '0;
            ram_wdata <= DW'(pat(PAT_W'(SEED), '0));
            busy      <= 1'b1;
          end
        end
        WRITE: begin
          if (cnt == LAST_ADDR) begin
            state    <= READ;
            cnt      <= '0;
            ram_wren <= 1'b0;
            ram_rden <= 1'b1;
            ram_addr <= '0;
          end else begin
            cnt       <= cnt_nx;
            ram_addr  <= cnt_nx;
            ram_wdata <= DW'(pat(seed_q, PAT_W'(cnt_nx)));
          end
        end
        READ: begin
          if (cnt == LAST_ADDR) begin
            state    <= DRAIN;
            cnt      <= '0;
            dcnt     <= '0;
            ram_rden <= 1'b0;
          end else begin
            cnt      <= cnt_nx;
            ram_addr <= cnt_nx;
          end
        end
        DRAIN: begin
          if (dcnt == DRAIN_LAST) begin
            done <= 1'b1;
`ifdef RAM_RW_CTRL_LOOP_EN
            state     <= WRITE;
            seed_q    <= seed_q + PAT_W'(1);
            ram_wren  <= 1'b1;
            ram_addr  <= '0;
            ram_wdata <= DW'(pat(seed_q + PAT_W'(1), '0));
`else
            state <= IDLE;
            busy  <= 1'b0;
`endif
          end else begin
            dcnt <= dcnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        err_flag <= 1'b0;
        err_cnt  <= '0;
      end else if (mismatch) begin
        err_flag <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + ECW'(1);
      end
    end
  end

endmodule
